// File: rtl/fb_sched_pkg.sv
// Shared types and defaults for the framebuffer write scheduler.
package fb_sched_pkg;

  localparam int unsigned H_RES_DEF   = 640;
  localparam int unsigned V_RES_DEF   = 480;
  localparam int unsigned ADDR_W_DEF  = 19;
  localparam int unsigned DATA_W_DEF  = 24;
  localparam int unsigned COORD_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_FILL
  } grant_t;

  // Multiply by a constant using only shifts and adds, one term per set bit
  // of k (640 = 512 + 128 gives two terms).
  function automatic logic [31:0] shift_add_mul(input logic [31:0] y,
                                                input int unsigned k);
    logic [31:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (y << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fb_rr_arbiter.sv
// Two-way round-robin arbiter between CPU pixel writes and the fill engine.
module fb_rr_arbiter
  import fb_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_cpu,
  input  logic req_fill,
  output logic gnt_cpu,
  output logic gnt_fill
);

  grant_t last_grant;

  // Lone requester wins; on contention the side not granted last time wins.
  always_comb begin
    gnt_cpu  = req_cpu && (!req_fill || (last_grant == GNT_FILL));
    gnt_fill = req_fill && !gnt_cpu;
  end

  // Remember the most recent winner; reset favours the CPU on first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GNT_FILL;
    end else if (gnt_cpu) begin
      last_grant <= GNT_CPU;
    end else if (gnt_fill) begin
      last_grant <= GNT_FILL;
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port scheduler: merges CPU single-pixel writes with a
// rectangle-fill engine. Fill addresses are stepped incrementally from a
// per-row base, so the pixel loop contains adders only.
// Optional macro FB_FILL_CLIP_EN clips fill rectangles to the visible area.
module fb_write_scheduler
  import fb_sched_pkg::*;
#(
  parameter int unsigned H_RES   = H_RES_DEF,
  parameter int unsigned V_RES   = V_RES_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned COORD_W = COORD_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPU_REQ,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DATA,
  output logic              CPU_ACK,
  input  logic              FILL_START,
  input  logic [COORD_W-1:0] FILL_X,
  input  logic [COORD_W-1:0] FILL_Y,
  input  logic [COORD_W-1:0] FILL_W,
  input  logic [COORD_W-1:0] FILL_H,
  input  logic [DATA_W-1:0] FILL_COLOR,
  output logic              FILL_BUSY,
  output logic              FILL_DONE,
  output logic              WRITE_EN,
  output logic [ADDR_W-1:0] WRITE_ADDR,
  output logic [DATA_W-1:0] WRITE_DATA
);

  // A full frame must be addressable.
  if ((64'(H_RES) * 64'(V_RES)) > (64'd1 << ADDR_W)) begin : g_cfg_check
    $error("fb_write_scheduler: ADDR_W too small for H_RES*V_RES");
  end

  fill_state_t        state;
  logic [COORD_W-1:0] x_q, w_q, h_q;
  logic [COORD_W-1:0] col, row;
  logic [ADDR_W-1:0]  row_base;
  logic [DATA_W-1:0]  color_q;
  logic [COORD_W-1:0] eff_w, eff_h;
  logic [ADDR_W-1:0]  fill_addr;
  logic               req_cpu, req_fill;
  logic               gnt_cpu, gnt_fill;

  // Keep grants (and thus CPU_ACK) low while reset is asserted.
  assign req_cpu  = CPU_REQ && !RST;
  assign req_fill = (state == FILL);
  assign CPU_ACK  = gnt_cpu;

  fb_rr_arbiter u_arb (
    .clk      (CLK),
    .rst      (RST),
    .req_cpu  (req_cpu),
    .req_fill (req_fill),
    .gnt_cpu  (gnt_cpu),
    .gnt_fill (gnt_fill)
  );

`ifdef FB_FILL_CLIP_EN
  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
  localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);
  logic [COORD_W:0] x_room, y_room;

  // Clip the requested size to what remains of the visible frame.
  always_comb begin
    x_room = H_LIM - {1'b0, FILL_X};
    y_room = V_LIM - {1'b0, FILL_Y};
    eff_w  = FILL_W;
    eff_h  = FILL_H;
    if ({1'b0, FILL_X} >= H_LIM)       eff_w = '0;
    else if ({1'b0, FILL_W} > x_room)  eff_w = x_room[COORD_W-1:0];
    if ({1'b0, FILL_Y} >= V_LIM)       eff_h = '0;
    else if ({1'b0, FILL_H} > y_room)  eff_h = y_room[COORD_W-1:0];
  end
`else
  // Unclipped: the caller keeps the rectangle inside the frame.
  always_comb begin
    eff_w = FILL_W;
    eff_h = FILL_H;
  end
`endif

  // Current fill pixel address, modulo 2^ADDR_W.
  always_comb begin
    fill_addr = row_base + ADDR_W'(x_q) + ADDR_W'(col);
  end

  // Fill FSM: operand latch, column/row stepping on granted pixels, done pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      x_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      color_q   <= '0;
      FILL_BUSY <= 1'b0;
      FILL_DONE <= 1'b0;
    end else begin
      FILL_DONE <= 1'b0;
      case (state)
        IDLE: begin
          // BUSY is still high during the done-pulse cycle, so a start there is ignored.
          if (FILL_START && !FILL_BUSY) begin
            x_q       <= FILL_X;
            w_q       <= eff_w;
            h_q       <= eff_h;
            color_q   <= FILL_COLOR;
            col       <= '0;
            row       <= '0;
            row_base  <= ADDR_W'(shift_add_mul(32'(FILL_Y), H_RES));
            FILL_BUSY <= 1'b1;
            if ((eff_w == '0) || (eff_h == '0)) state <= DONE;
            else                                state <= FILL;
          end else begin
            FILL_BUSY <= 1'b0;
          end
        end
        FILL: begin
          if (gnt_fill) begin
            if (col == (w_q - COORD_W'(1))) begin
              col      <= '0;
              row      <= row + COORD_W'(1);
              row_base <= row_base + ADDR_W'(H_RES);
              if (row == (h_q - COORD_W'(1))) state <= DONE;
            end else begin
              col <= col + COORD_W'(1);
            end
          end
        end
        DONE: begin
          FILL_DONE <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered write port: strobe only in cycles after a grant, data/addr hold otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WRITE_EN   <= 1'b0;
      WRITE_ADDR <= '0;
      WRITE_DATA <= '0;
    end else begin
      WRITE_EN <= gnt_cpu || gnt_fill;
      if (gnt_cpu) begin
        WRITE_ADDR <= CPU_ADDR;
        WRITE_DATA <= CPU_DATA;
      end else if (gnt_fill) begin
        WRITE_ADDR <= fill_addr;
        WRITE_DATA <= color_q;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed self-checking bench for fb_write_scheduler.
module tb_fb_write_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CPU_REQ = 1'b0;
  logic [18:0] CPU_ADDR = '0;
  logic [23:0] CPU_DATA = '0;
  logic        CPU_ACK;
  logic        FILL_START = 1'b0;
  logic [9:0]  FILL_X = '0, FILL_Y = '0, FILL_W = '0, FILL_H = '0;
  logic [23:0] FILL_COLOR = '0;
  logic        FILL_BUSY, FILL_DONE, WRITE_EN;
  logic [18:0] WRITE_ADDR;
  logic [23:0] WRITE_DATA;

  fb_write_scheduler #(
    .H_RES(640), .V_RES(480), .ADDR_W(19), .DATA_W(24), .COORD_W(10)
  ) dut (
    .CLK(CLK), .RST(RST),
    .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_DATA(CPU_DATA), .CPU_ACK(CPU_ACK),
    .FILL_START(FILL_START), .FILL_X(FILL_X), .FILL_Y(FILL_Y), .FILL_W(FILL_W),
    .FILL_H(FILL_H), .FILL_COLOR(FILL_COLOR), .FILL_BUSY(FILL_BUSY), .FILL_DONE(FILL_DONE),
    .WRITE_EN(WRITE_EN), .WRITE_ADDR(WRITE_ADDR), .WRITE_DATA(WRITE_DATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Write/pulse log sampled on the falling edge.
  int          wq_addr[$];
  int          wq_data[$];
  int          wq_cyc[$];
  int          done_cnt = 0, done_cyc = -1;
  int          ack_cnt = 0, ack_cyc = -1;
  always @(negedge CLK) begin
    if (WRITE_EN) begin
      wq_addr.push_back(int'(WRITE_ADDR));
      wq_data.push_back(int'(WRITE_DATA));
      wq_cyc.push_back(cyc);
    end
    if (FILL_DONE) begin done_cnt++; done_cyc = cyc; end
    if (CPU_ACK)   begin ack_cnt++;  ack_cyc  = cyc; end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic start_fill(input int x, input int y, input int w, input int h,
                            input logic [23:0] c, output int scyc);
    @(posedge CLK); #1;
    FILL_X = 10'(x); FILL_Y = 10'(y); FILL_W = 10'(w); FILL_H = 10'(h);
    FILL_COLOR = c; FILL_START = 1'b1; scyc = cyc;
    @(posedge CLK); #1;
    FILL_START = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, d, a, k, exp_n;
    int exp_seq[10];
    logic [63:0] sum;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_we",   WRITE_EN,   0);
    chk("rst_addr", WRITE_ADDR, 0);
    chk("rst_data", WRITE_DATA, 0);
    chk("rst_ack",  CPU_ACK,    0);
    chk("rst_busy", FILL_BUSY,  0);
    chk("rst_done", FILL_DONE,  0);
    @(posedge CLK); #1 RST = 1'b0;
    repeat (2) @(posedge CLK);

    // Single CPU write
    b = wq_addr.size(); a = ack_cnt;
    #1 CPU_REQ = 1'b1; CPU_ADDR = 19'h12345; CPU_DATA = 24'hFF0000;
    @(posedge CLK); #1 CPU_REQ = 1'b0;
    repeat (4) @(posedge CLK);
    chk("cpu_acks", ack_cnt - a, 1);
    chk("cpu_nwr", wq_addr.size() - b, 1);
    if (wq_addr.size() > b) begin
      chk("cpu_addr", wq_addr[b], 32'h12345);
      chk("cpu_data", wq_data[b], 32'hFF0000);
      chk("cpu_lat",  wq_cyc[b] - ack_cyc, 1);
    end

    // 3x2 fill at (10,2)
    b = wq_addr.size(); d = done_cnt;
    start_fill(10, 2, 3, 2, 24'h00FF00, k);
    repeat (15) @(posedge CLK);
    chk("f32_nwr", wq_addr.size() - b, 6);
    chk("f32_done", done_cnt - d, 1);
    exp_seq[0] = 1290; exp_seq[1] = 1291; exp_seq[2] = 1292;
    exp_seq[3] = 1930; exp_seq[4] = 1931; exp_seq[5] = 1932;
    if (wq_addr.size() - b == 6) begin
      chk("f32_first_cyc", wq_cyc[b], k + 2);
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("f32_addr%0d", i), wq_addr[b+i], exp_seq[i]);
        chk($sformatf("f32_data%0d", i), wq_data[b+i], 32'h00FF00);
        chk($sformatf("f32_cyc%0d", i), wq_cyc[b+i], wq_cyc[b] + i);
      end
    end

    // 4x1 fill at (0,0) with CPU_REQ held: CPU wins first, then strict alternation
    b = wq_addr.size(); d = done_cnt; a = ack_cnt;
    @(posedge CLK); #1;
    FILL_X = '0; FILL_Y = '0; FILL_W = 10'd4; FILL_H = 10'd1; FILL_COLOR = 24'h0000AA;
    FILL_START = 1'b1; CPU_REQ = 1'b1; CPU_ADDR = 19'h7000; CPU_DATA = 24'h123456;
    @(posedge CLK); #1 FILL_START = 1'b0;
    repeat (9) @(posedge CLK);
    #1 CPU_REQ = 1'b0;
    repeat (5) @(posedge CLK);
    chk("rr_nwr", wq_addr.size() - b, 10);
    chk("rr_acks", ack_cnt - a, 6);
    chk("rr_done", done_cnt - d, 1);
    exp_seq[0] = 32'h7000; exp_seq[1] = 0; exp_seq[2] = 32'h7000; exp_seq[3] = 1;
    exp_seq[4] = 32'h7000; exp_seq[5] = 2; exp_seq[6] = 32'h7000; exp_seq[7] = 3;
    exp_seq[8] = 32'h7000; exp_seq[9] = 32'h7000;
    if (wq_addr.size() - b == 10) begin
      for (int i = 0; i < 10; i++)
        chk($sformatf("rr_seq%0d", i), wq_addr[b+i], exp_seq[i]);
    end

    // Zero-width fill: done two cycles after the start pulse, no writes
    b = wq_addr.size(); d = done_cnt;
    start_fill(5, 5, 0, 3, 24'h111111, k);
    repeat (5) @(posedge CLK);
    chk("w0_nwr", wq_addr.size() - b, 0);
    chk("w0_done", done_cnt - d, 1);
    chk("w0_done_cyc", done_cyc, k + 2);

    // 8x8 fill with an ignored second start
    b = wq_addr.size(); d = done_cnt;
    start_fill(0, 0, 8, 8, 24'h0F0F0F, k);
    repeat (3) @(posedge CLK);
    #1 FILL_X = 10'd100; FILL_Y = 10'd100; FILL_W = 10'd2; FILL_H = 10'd2;
    FILL_COLOR = 24'hEEEEEE; FILL_START = 1'b1;
    @(posedge CLK); #1 FILL_START = 1'b0;
    repeat (80) @(posedge CLK);
    chk("f88_nwr", wq_addr.size() - b, 64);
    chk("f88_done", done_cnt - d, 1);
    sum = '0;
    for (int i = b; i < wq_addr.size(); i++) sum += 64'(wq_addr[i]);
    chk("f88_sum", sum, 143584);
    if (wq_addr.size() - b == 64) begin
      chk("f88_last", wq_addr[b+63], 4487);
      chk("f88_data", wq_data[b+63], 32'h0F0F0F);
    end

    // Corner fill (638,479) 5x5
    b = wq_addr.size(); d = done_cnt;
    start_fill(638, 479, 5, 5, 24'h222222, k);
    repeat (40) @(posedge CLK);
`ifdef FB_FILL_CLIP_EN
    exp_n = 2;
`else
    exp_n = 25;
`endif
    chk("clip_nwr", wq_addr.size() - b, exp_n);
    chk("clip_done", done_cnt - d, 1);
    if (wq_addr.size() - b == exp_n) begin
      chk("clip_first", wq_addr[b], 307198);
      chk("clip_last", wq_addr[b+exp_n-1], (exp_n == 2) ? 307199 : 309762);
    end

    // Reset during the 3rd pixel of a 4x4 fill
    b = wq_addr.size(); d = done_cnt;
    start_fill(0, 0, 4, 4, 24'h333333, k);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("arst_we",   WRITE_EN,   0);
    chk("arst_addr", WRITE_ADDR, 0);
    chk("arst_data", WRITE_DATA, 0);
    chk("arst_busy", FILL_BUSY,  0);
    chk("arst_done", FILL_DONE,  0);
    @(posedge CLK); @(posedge CLK); #1 RST = 1'b0;
    repeat (10) @(posedge CLK);
    chk("arst_nwr", wq_addr.size() - b, 2);
    chk("arst_nodone", done_cnt - d, 0);

    b = wq_addr.size(); d = done_cnt;
    start_fill(0, 0, 1, 1, 24'hABCDEF, k);
    repeat (6) @(posedge CLK);
    chk("post_nwr", wq_addr.size() - b, 1);
    chk("post_done", done_cnt - d, 1);
    if (wq_addr.size() - b == 1) begin
      chk("post_addr", wq_addr[b], 0);
      chk("post_data", wq_data[b], 32'hABCDEF);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Sequences all writes into the FrameBuffer write port (WRITE_ADDR/WRITE_DATA, write strobe) on a single clock.
- Shares the port between two requesters: single-pixel writes from the Nios PIO path, and an internal rectangle-fill engine used to draw the ball and paddle overlays.
- Converts (x,y) to the linear address y*H_RES+x incrementally, with no multiplier in the pixel loop.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines
- ADDR_W, 19, framebuffer address width
- DATA_W, 24, pixel width {R,G,B}
- COORD_W, 10, x/y/width/height field width

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- CPU_REQ  in  1  single-pixel write request; level, held until CPU_ACK
- CPU_ADDR  in  ADDR_W  linear pixel address
- CPU_DATA  in  DATA_W  pixel value
- CPU_ACK  out  1  one-cycle pulse when the CPU write is granted
- FILL_START  in  1  one-cycle pulse; latches the FILL_* operands
- FILL_X  in  COORD_W  rectangle left edge
- FILL_Y  in  COORD_W  rectangle top edge
- FILL_W  in  COORD_W  rectangle width in pixels
- FILL_H  in  COORD_W  rectangle height in pixels
- FILL_COLOR  in  DATA_W  fill value
- FILL_BUSY  out  1  high while a fill is in progress
- FILL_DONE  out  1  one-cycle pulse when a fill completes
- WRITE_EN  out  1  framebuffer write strobe, one cycle per pixel
- WRITE_ADDR  out  ADDR_W  framebuffer address
- WRITE_DATA  out  DATA_W  framebuffer data

Behaviour:
- Reset: all outputs 0; FSM in IDLE; last_grant = FILL, so the CPU wins the first contention.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - FILL_START with W≠0 and H≠0 → latch operands; row_base = Y*H_RES (computed once with shift-add, 640 = 512+128); col = 0; row = 0 → FILL.
  - FILL_START with W=0 or H=0 → DONE directly; no pixels written.
- FILL: issues one pixel per granted cycle.
  - Address = row_base + X + col.
  - col increments per granted pixel. When col = W-1: col ← 0, row++, row_base += H_RES.
  - Granted pixel at row = H-1 and col = W-1 → DONE.
- DONE: FILL_DONE = 1 for exactly one cycle → IDLE. FILL_BUSY = 1 in FILL and DONE.
- FILL_START while FILL_BUSY is ignored and does not alter the latched operands.
- Arbitration, evaluated each cycle:
  - Only one side pending → that side is granted.
  - Both pending → the side not in last_grant is granted (round-robin); last_grant updates on every grant.
  - An ungranted fill pixel stalls: col/row hold.
- CPU grant: CPU_ACK pulses in the grant cycle. The CPU must drop or change CPU_REQ in the cycle after ACK; a REQ still high then is a new request.
- Output latency:
  - WRITE_EN/ADDR/DATA are registered and appear one cycle after grant.
  - WRITE_EN = 0 in cycles with no grant; ADDR/DATA hold their last value.
  - Maximum throughput is one write per cycle.
- Widths: row_base and address arithmetic are ADDR_W bits; overflow truncates modulo 2^ADDR_W.
- RST asserted mid-fill: the fill is abandoned immediately; no FILL_DONE is issued.

Optional Feature:
- Macro: FB_FILL_CLIP_EN.
- Defined:
  - At FILL_START the effective width is min(W, H_RES-X) and the effective height is min(H, V_RES-Y).
  - X ≥ H_RES or Y ≥ V_RES → zero-size fill (DONE, no writes).
- Undefined:
  - No clipping; out-of-range pixels are written at computed addresses.
  - Callers guarantee X+W ≤ H_RES and Y+H ≤ V_RES.

Decomposition:
- Package fb_sched_pkg:
  - Parameter defaults H_RES, V_RES, ADDR_W, DATA_W, COORD_W.
  - State enum {IDLE, FILL, DONE}.
  - Grant enum {GNT_CPU, GNT_FILL}.
- Sub-module fb_rr_arbiter: 2-way round-robin arbiter holding last_grant.
- Address stepping and FSM stay in the top module.

Test Plan:
- CPU_REQ with ADDR=0x12345, DATA=0xFF0000, no fill active → CPU_ACK at cycle t; WRITE_EN=1 with ADDR=0x12345, DATA=0xFF0000 at t+1; exactly one write.
- FILL_START X=10, Y=2, W=3, H=2, COLOR=0x00FF00 → writes to 1290, 1291, 1292, 1930, 1931, 1932 on consecutive cycles; FILL_DONE pulses once; 6 writes total.
- Fill of 4x1 at (0,0) with CPU_REQ held continuously → grants alternate CPU, FILL, CPU, …; all 4 fill pixels and every CPU ACK appear; no address skipped or duplicated.
- FILL_START with W=0 → FILL_DONE pulses 2 cycles later; WRITE_EN never asserts. A second FILL_START during a busy 8x8 fill → ignored; exactly 64 writes.
- FB_FILL_CLIP_EN: X=638, Y=479, W=5, H=5 → exactly 2 writes, at 307198 and 307199. Without the macro → 25 writes.
- RST pulse at the 3rd pixel of a 4x4 fill → all outputs 0 asynchronously; no FILL_DONE. After release, a new fill of 1x1 at (0,0) → single write to address 0.
